// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - instruction fetch stage with in-order fetch queue and redirect handling
//
// Generates fetch PCs, issues them on a split addr_ok/data_ok instruction SRAM
// port with up to FQ_DEPTH requests in flight, and buffers the returned
// instructions in an in-order queue in front of decode.
//
// Ports:
//   clk_i, reset_i        clock, asynchronous active-high reset
//   ds_allowin_i          decode accepts the queue head this cycle
//   br_bus_i[33:0]        {br_stall, br_taken, br_target[31:0]} from decode
//   ws_ex_i               writeback exception, redirect to EX_ENTRY
//   eret_i, cp0_epc_i     return from exception, redirect to cp0_epc_i
//   fs_to_ds_valid_o      queue head valid
//   fs_to_ds_bus_o        {pc_error, BadVAddr[31:0], ex_code[4:0], inst[31:0], pc[31:0]}
//   inst_req_o            fetch request
//   inst_addr_o           word-aligned fetch address
//   inst_addr_ok_i        request accepted this cycle
//   inst_data_ok_i        in-order response valid this cycle
//   inst_rdata_i          response data
//
// Optional feature macro: FS_ADEL_CHECK_EN (misaligned-PC exception tagging).

`ifndef NO_EX
`define NO_EX 5'h00
`endif
`ifndef ADEL
`define ADEL 5'h04
`endif

module if_fetch_queue #(
   parameter int unsigned FQ_DEPTH = 4,
   parameter logic [31:0] RESET_PC = 32'hbfc00000,
   parameter logic [31:0] EX_ENTRY = 32'hbfc00380
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          ds_allowin_i,
   input  logic [33:0]   br_bus_i,
   input  logic          ws_ex_i,
   input  logic          eret_i,
   input  logic [31:0]   cp0_epc_i,
   output logic          fs_to_ds_valid_o,
   output logic [101:0]  fs_to_ds_bus_o,
   output logic          inst_req_o,
   output logic [31:0]   inst_addr_o,
   input  logic          inst_addr_ok_i,
   input  logic          inst_data_ok_i,
   input  logic [31:0]   inst_rdata_i
);

   localparam int unsigned AW = $clog2(FQ_DEPTH);
   localparam int unsigned CW = $clog2(FQ_DEPTH + 1);
   localparam logic [CW:0] DEPTH_C = (CW+1)'(FQ_DEPTH);

   typedef enum logic [1:0] {
      SLOT_IDLE       = 2'd0,
      SLOT_WAIT_RESP  = 2'd1,
      SLOT_WAIT_ISSUE = 2'd2
   } slot_e;

   logic          br_stall;
   logic          br_taken;
   logic [31:0]   br_target;
   logic          flush;

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   pend_target_q, pend_target_d;
   slot_e         slot_q, slot_d;
   logic          hold_q, hold_d;
   logic [CW-1:0] out_cnt_q, out_cnt_d;
   logic [CW-1:0] disc_cnt_q, disc_cnt_d;
   logic [CW-1:0] q_cnt_q, q_cnt_d;
   logic [AW-1:0] q_head_q, q_head_d;
   logic [AW-1:0] fl_head_q, fl_head_d;

   logic [31:0]   fl_pc_q   [FQ_DEPTH];
   logic [31:0]   q_pc_q    [FQ_DEPTH];
   logic [31:0]   q_inst_q  [FQ_DEPTH];

   logic [CW:0]   occ;
   logic          issue;
   logic          resp;
   logic          keep_resp;
   logic          drop_resp;
   logic          pop;
   logic          push;
   logic [31:0]   resp_pc;
   logic [AW-1:0] fl_wr_idx;
   logic [AW-1:0] q_wr_idx;
   logic [CW-1:0] out_left;
   logic [31:0]   head_pc;
   logic [31:0]   head_inst;
   logic          head_ex;

   assign br_stall  = br_bus_i[33];
   assign br_taken  = br_bus_i[32];
   assign br_target = br_bus_i[31:0];
   assign flush     = ws_ex_i | eret_i;

   // Queue entries plus in-flight requests never exceed FQ_DEPTH, so every
   // response always has a queue slot waiting for it.
   assign occ        = {1'b0, q_cnt_q} + {1'b0, out_cnt_q};
   assign inst_req_o = !reset_i && !hold_q && !br_stall && !flush && !br_taken && (occ < DEPTH_C);
   assign inst_addr_o = {fetch_pc_q[31:2], 2'b00};

   assign issue = inst_req_o & inst_addr_ok_i;
   // data_ok with nothing outstanding is ignored so a tied-high data_ok is harmless.
   assign resp  = inst_data_ok_i & (out_cnt_q != '0);
   // While waiting for a delay slot, the next response is the slot itself and
   // is kept; disc_cnt then counts the wrong-path responses behind it.
   assign keep_resp = resp & ((disc_cnt_q == '0) | (slot_q == SLOT_WAIT_RESP));
   assign drop_resp = resp & ~keep_resp;
   assign pop       = fs_to_ds_valid_o & ds_allowin_i;

   assign resp_pc   = fl_pc_q[fl_head_q];
   assign fl_wr_idx = fl_head_q + out_cnt_q[AW-1:0];
   assign q_wr_idx  = q_head_q + q_cnt_q[AW-1:0];
   assign out_left  = out_cnt_q - CW'(resp);

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      pend_target_d = pend_target_q;
      slot_d        = slot_q;
      hold_d        = hold_q;
      out_cnt_d     = out_left + CW'(issue);
      disc_cnt_d    = disc_cnt_q - CW'(drop_resp);
      q_cnt_d       = q_cnt_q + CW'(keep_resp) - CW'(pop);
      q_head_d      = q_head_q + AW'(pop);
      fl_head_d     = fl_head_q + AW'(resp);
      push          = keep_resp;

      if (issue) begin
         if (slot_q == SLOT_WAIT_ISSUE) begin
            // This request was the delay slot; the branch target follows it.
            fetch_pc_d = pend_target_q;
            slot_d     = SLOT_IDLE;
         end else begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
`ifdef FS_ADEL_CHECK_EN
         if (fetch_pc_q[1:0] != 2'b00) begin
            hold_d = 1'b1;
         end
`endif
      end

      if (keep_resp && (slot_q == SLOT_WAIT_RESP)) begin
         slot_d = SLOT_IDLE;
      end

      if (flush) begin
         fetch_pc_d = ws_ex_i ? EX_ENTRY : cp0_epc_i;
         q_cnt_d    = '0;
         push       = 1'b0;
         disc_cnt_d = out_left;
         hold_d     = 1'b0;
         slot_d     = SLOT_IDLE;
      end else if (br_taken) begin
         slot_d = SLOT_IDLE;
         if (q_cnt_q != '0) begin
            // Head is the delay slot; if decode takes it now nothing survives.
            q_cnt_d    = pop ? '0 : CW'(1);
            push       = 1'b0;
            disc_cnt_d = out_left;
            fetch_pc_d = br_target;
         end else if (keep_resp) begin
            // The delay slot arrives this very cycle.
            q_cnt_d    = CW'(1);
            disc_cnt_d = out_left;
            fetch_pc_d = br_target;
         end else if (out_left != '0) begin
            disc_cnt_d = out_left - CW'(1);
            fetch_pc_d = br_target;
            slot_d     = SLOT_WAIT_RESP;
         end else begin
            // Delay slot not yet requested: fetch it at fetch_pc first.
            pend_target_d = br_target;
            slot_d        = SLOT_WAIT_ISSUE;
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         fetch_pc_q    <= RESET_PC;
         pend_target_q <= 32'h0;
         slot_q        <= SLOT_IDLE;
         hold_q        <= 1'b0;
         out_cnt_q     <= '0;
         disc_cnt_q    <= '0;
         q_cnt_q       <= '0;
         q_head_q      <= '0;
         fl_head_q     <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         pend_target_q <= pend_target_d;
         slot_q        <= slot_d;
         hold_q        <= hold_d;
         out_cnt_q     <= out_cnt_d;
         disc_cnt_q    <= disc_cnt_d;
         q_cnt_q       <= q_cnt_d;
         q_head_q      <= q_head_d;
         fl_head_q     <= fl_head_d;
      end
   end

   // Storage arrays need no reset: contents are only observed through valid counts.
   always_ff @(posedge clk_i) begin
      if (issue) begin
         fl_pc_q[fl_wr_idx] <= fetch_pc_q;
      end
      if (push) begin
         q_pc_q[q_wr_idx]   <= resp_pc;
         q_inst_q[q_wr_idx] <= inst_rdata_i;
      end
   end

   assign fs_to_ds_valid_o = (q_cnt_q != '0);
   assign head_pc   = q_pc_q[q_head_q];
   assign head_inst = q_inst_q[q_head_q];

`ifdef FS_ADEL_CHECK_EN
   // The exception tag follows from the stored PC: only misaligned requests carry it.
   assign head_ex = (head_pc[1:0] != 2'b00);
`else
   assign head_ex = 1'b0;
`endif

   assign fs_to_ds_bus_o = fs_to_ds_valid_o ?
                           {head_ex, (head_ex ? head_pc : 32'h0), (head_ex ? `ADEL : `NO_EX), head_inst, head_pc} :
                           '0;

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - self-checking bench for if_fetch_queue
module tb_if_fetch_queue;

   logic          clk = 1'b0;
   logic          reset;
   logic          ds_allowin;
   logic [33:0]   br_bus;
   logic          ws_ex;
   logic          eret;
   logic [31:0]   cp0_epc;
   logic          fs_to_ds_valid;
   logic [101:0]  fs_to_ds_bus;
   logic          inst_req;
   logic [31:0]   inst_addr;
   logic          addr_ok;
   logic          data_ok;
   logic [31:0]   rdata;

   int            checks = 0;
   int            failures = 0;

   logic [31:0]   pend[$];
   logic [101:0]  got[$];
   logic          dok_en;

   logic          s_req;
   logic [31:0]   s_addr;
   logic          s_valid;
   logic [101:0]  s_bus;

   typedef struct {
      logic        allow;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t vt[22];

   if_fetch_queue dut (
      .clk_i            (clk),
      .reset_i          (reset),
      .ds_allowin_i     (ds_allowin),
      .br_bus_i         (br_bus),
      .ws_ex_i          (ws_ex),
      .eret_i           (eret),
      .cp0_epc_i        (cp0_epc),
      .fs_to_ds_valid_o (fs_to_ds_valid),
      .fs_to_ds_bus_o   (fs_to_ds_bus),
      .inst_req_o       (inst_req),
      .inst_addr_o      (inst_addr),
      .inst_addr_ok_i   (addr_ok),
      .inst_data_ok_i   (data_ok),
      .inst_rdata_i     (rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] exp_inst(input logic [31:0] pc);
      return ~{pc[31:2], 2'b00};
   endfunction

   task automatic check(input string name, input logic [101:0] act, input logic [101:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic check_got(input int idx, input logic [31:0] exp_pc, input string name);
      if (got.size() > idx) begin
         check({name, "_pc"}, got[idx][31:0], exp_pc);
         check({name, "_inst"}, got[idx][63:32], exp_inst(exp_pc));
      end else begin
         checks++;
         failures++;
         $display("FAIL %s: actual=%0d delivered required>%0d", name, got.size(), idx);
      end
   endtask

   // One clock: SRAM model drives data_ok at the falling edge, outputs are
   // sampled there, and the model queue is updated just after the rising edge.
   task automatic tick();
      logic acc;
      @(negedge clk);
      data_ok = !reset && dok_en && (pend.size() != 0);
      rdata   = data_ok ? ~pend[0] : 32'h0;
      #1;
      s_req   = inst_req;
      s_addr  = inst_addr;
      s_valid = fs_to_ds_valid;
      s_bus   = fs_to_ds_bus;
      acc     = s_req && addr_ok;
      if (!reset && s_valid && ds_allowin && !ws_ex && !eret) got.push_back(s_bus);
      @(posedge clk);
      #1;
      if (reset) begin
         pend.delete();
      end else begin
         if (data_ok) pend.delete(0);
         if (acc) pend.push_back(s_addr);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; ds_allowin = 1'b0; br_bus = '0; ws_ex = 1'b0;
      eret = 1'b0; cp0_epc = 32'h0; dok_en = 1'b0; addr_ok = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      got.delete();
   endtask

   initial begin
      logic [101:0] e;
      data_ok = 1'b0;
      rdata   = 32'h0;

      //            allow req  addr          valid pc
      vt[0]  = '{1'b1, 1'b1, 32'hbfc00000, 1'b0, 32'h0};
      vt[1]  = '{1'b1, 1'b1, 32'hbfc00004, 1'b0, 32'h0};
      vt[2]  = '{1'b1, 1'b1, 32'hbfc00008, 1'b1, 32'hbfc00000};
      vt[3]  = '{1'b1, 1'b1, 32'hbfc0000c, 1'b1, 32'hbfc00004};
      vt[4]  = '{1'b1, 1'b1, 32'hbfc00010, 1'b1, 32'hbfc00008};
      vt[5]  = '{1'b1, 1'b1, 32'hbfc00014, 1'b1, 32'hbfc0000c};
      vt[6]  = '{1'b0, 1'b1, 32'hbfc00018, 1'b1, 32'hbfc00010};
      vt[7]  = '{1'b0, 1'b1, 32'hbfc0001c, 1'b1, 32'hbfc00010};
      vt[8]  = '{1'b0, 1'b0, 32'hbfc00020, 1'b1, 32'hbfc00010};
      vt[9]  = '{1'b0, 1'b0, 32'hbfc00020, 1'b1, 32'hbfc00010};
      vt[10] = '{1'b0, 1'b0, 32'hbfc00020, 1'b1, 32'hbfc00010};
      vt[11] = '{1'b0, 1'b0, 32'hbfc00020, 1'b1, 32'hbfc00010};
      vt[12] = '{1'b0, 1'b0, 32'hbfc00020, 1'b1, 32'hbfc00010};
      vt[13] = '{1'b0, 1'b0, 32'hbfc00020, 1'b1, 32'hbfc00010};
      vt[14] = '{1'b0, 1'b0, 32'hbfc00020, 1'b1, 32'hbfc00010};
      vt[15] = '{1'b0, 1'b0, 32'hbfc00020, 1'b1, 32'hbfc00010};
      vt[16] = '{1'b1, 1'b0, 32'hbfc00020, 1'b1, 32'hbfc00010};
      vt[17] = '{1'b1, 1'b1, 32'hbfc00020, 1'b1, 32'hbfc00014};
      vt[18] = '{1'b1, 1'b1, 32'hbfc00024, 1'b1, 32'hbfc00018};
      vt[19] = '{1'b1, 1'b1, 32'hbfc00028, 1'b1, 32'hbfc0001c};
      vt[20] = '{1'b1, 1'b1, 32'hbfc0002c, 1'b1, 32'hbfc00020};
      vt[21] = '{1'b1, 1'b1, 32'hbfc00030, 1'b1, 32'hbfc00024};

      // Reset state
      do_reset();
      reset = 1'b1;
      tick();
      check("rst_valid", s_valid, 1'b0);
      check("rst_req", s_req, 1'b0);
      check("rst_bus", s_bus, '0);
      reset = 1'b0;

      // Streaming with a 10-cycle decode stall
      dok_en = 1'b1;
      for (int i = 0; i < 22; i++) begin
         ds_allowin = vt[i].allow;
         tick();
         check($sformatf("t%0d_req", i), s_req, vt[i].exp_req);
         if (vt[i].exp_req) check($sformatf("t%0d_addr", i), s_addr, vt[i].exp_addr);
         check($sformatf("t%0d_valid", i), s_valid, vt[i].exp_valid);
         if (vt[i].exp_valid) begin
            check($sformatf("t%0d_pc", i), s_bus[31:0], vt[i].exp_pc);
            check($sformatf("t%0d_inst", i), s_bus[63:32], exp_inst(vt[i].exp_pc));
            check($sformatf("t%0d_err", i), s_bus[101], 1'b0);
         end
      end

      // Reset in the middle of traffic
      reset = 1'b1;
      tick();
      check("midrst_valid", s_valid, 1'b0);
      check("midrst_req", s_req, 1'b0);
      check("midrst_bus", s_bus, '0);

      // Exception with 3 requests outstanding
      do_reset();
      ds_allowin = 1'b1;
      repeat (3) tick();
      ws_ex = 1'b1;
      tick();
      check("exc_req_blocked", s_req, 1'b0);
      ws_ex = 1'b0;
      dok_en = 1'b1;
      tick();
      check("exc_redirect_req", s_req, 1'b1);
      check("exc_redirect_addr", s_addr, 32'hbfc00380);
      repeat (12) tick();
      check_got(0, 32'hbfc00380, "exc_first");
      check_got(1, 32'hbfc00384, "exc_second");

      // Branch with two queued entries: head kept as delay slot
      do_reset();
      dok_en = 1'b1;
      eret = 1'b1; cp0_epc = 32'h00000100;
      tick();
      eret = 1'b0;
      repeat (3) tick();
      br_bus = {2'b01, 32'h80001000};
      tick();
      check("brq_req_blocked", s_req, 1'b0);
      br_bus = '0;
      ds_allowin = 1'b1;
      tick();
      check("brq_target_addr", s_addr, 32'h80001000);
      check("brq_head_pc", s_bus[31:0], 32'h00000100);
      repeat (8) tick();
      check_got(0, 32'h00000100, "brq_slot");
      check_got(1, 32'h80001000, "brq_target");
      check_got(2, 32'h80001004, "brq_target_next");

      // Branch with empty queue and nothing in flight: slot fetched first
      do_reset();
      dok_en = 1'b1; ds_allowin = 1'b1;
      eret = 1'b1; cp0_epc = 32'h00000100;
      tick();
      eret = 1'b0;
      br_bus = {2'b01, 32'h80001000};
      tick();
      check("bri_req_blocked", s_req, 1'b0);
      br_bus = '0;
      tick();
      check("bri_slot_addr", s_addr, 32'h00000100);
      tick();
      check("bri_target_addr", s_addr, 32'h80001000);
      repeat (8) tick();
      check_got(0, 32'h00000100, "bri_slot");
      check_got(1, 32'h80001000, "bri_target");
      check_got(2, 32'h80001004, "bri_target_next");

      // Branch with empty queue and two requests in flight
      do_reset();
      eret = 1'b1; cp0_epc = 32'h00000100;
      tick();
      eret = 1'b0;
      repeat (2) tick();
      br_bus = {2'b01, 32'h80001000};
      tick();
      check("brr_req_blocked", s_req, 1'b0);
      br_bus = '0;
      dok_en = 1'b1; ds_allowin = 1'b1;
      repeat (10) tick();
      check_got(0, 32'h00000100, "brr_slot");
      check_got(1, 32'h80001000, "brr_target");
      check_got(2, 32'h80001004, "brr_target_next");

      // br_stall: no issue, queue drains, responses still accepted
      do_reset();
      repeat (2) tick();
      br_bus = {2'b10, 32'h0};
      dok_en = 1'b1; ds_allowin = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("stall%0d_req", i), s_req, 1'b0);
      end
      check("stall_drained", got.size(), 2);
      check_got(0, 32'hbfc00000, "stall_first");
      check_got(1, 32'hbfc00004, "stall_second");
      br_bus = '0;
      addr_ok = 1'b0;
      tick();
      check("hold_req0", s_req, 1'b1);
      check("hold_addr0", s_addr, 32'hbfc00008);
      tick();
      check("hold_addr1", s_addr, 32'hbfc00008);
      addr_ok = 1'b1;
      tick();
      tick();
      check("hold_next_addr", s_addr, 32'hbfc0000c);

      // ERET to a misaligned PC
      do_reset();
      dok_en = 1'b1; ds_allowin = 1'b1;
      eret = 1'b1; cp0_epc = 32'h80000002;
      tick();
      eret = 1'b0;
      tick();
      check("adel_addr", s_addr, 32'h80000000);
      repeat (6) tick();
      check_got(0, 32'h80000002, "adel_entry");
      e = (got.size() > 0) ? got[0] : '1;
`ifdef FS_ADEL_CHECK_EN
      check("adel_pc_error", e[101], 1'b1);
      check("adel_badvaddr", e[100:69], 32'h80000002);
      check("adel_excode", e[68:64], 5'h04);
      check("adel_single", got.size(), 1);
      check("adel_req_held", s_req, 1'b0);
      ws_ex = 1'b1;
      tick();
      ws_ex = 1'b0;
      tick();
      check("adel_resume_req", s_req, 1'b1);
      check("adel_resume_addr", s_addr, 32'hbfc00380);
`else
      check("adel_pc_error", e[101], 1'b0);
      check("adel_badvaddr", e[100:69], 32'h0);
      check("adel_excode", e[68:64], 5'h00);
      check_got(1, 32'h80000006, "adel_next");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Parametrised instruction-fetch stage that decouples PC generation from decode through an in-order fetch queue. It sits between the CP0/writeback redirect sources and the decode stage. It drives a split request/response (addr_ok/data_ok) instruction-SRAM interface with up to FQ_DEPTH requests in flight. It handles branch redirect with delay-slot preservation, exception/ERET flush with cancellation of in-flight responses, and optional PC-alignment exception tagging.

## Interface
Reset is asynchronous and active-high.

Parameters:
- FQ_DEPTH, 4: queue entries and maximum in-flight requests combined; power of two, ≥2.
- RESET_PC, 32'hbfc00000: first fetch address after reset.
- EX_ENTRY, 32'hbfc00380: exception vector.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- ds_allowin  in  1  decode accepts an instruction this cycle.
- br_bus  in  34  {br_stall, br_taken, br_target[31:0]} from decode.
- ws_ex  in  1  writeback exception; redirect to EX_ENTRY.
- eret  in  1  redirect to cp0_epc.
- cp0_epc  in  32  ERET target.
- fs_to_ds_valid  out  1  queue head valid.
- fs_to_ds_bus  out  102  {pc_error, BadVAddr[31:0], ex_code[4:0], inst[31:0], pc[31:0]}.
- inst_req  out  1  fetch request.
- inst_addr  out  32  word-aligned fetch address {fetch_pc[31:2], 2'b0}.
- inst_addr_ok  in  1  request accepted this cycle.
- inst_data_ok  in  1  response valid this cycle, in request order.
- inst_rdata  in  32  response data.

## Operation
- State:
  - fetch_pc, reset RESET_PC.
  - in-flight PC FIFO, depth FQ_DEPTH.
  - out_cnt: total outstanding requests.
  - disc_cnt: outstanding requests to discard.
  - queue: FQ_DEPTH × {pc, inst, ex}, with count q_cnt.
  - hold flag.
  - slot state: SLOT_IDLE / SLOT_WAIT_RESP / SLOT_WAIT_ISSUE, plus pend_target.
- Issue:
  - inst_req = !hold && !br_stall && !ws_ex && !eret && !br_taken && (q_cnt + out_cnt < FQ_DEPTH).
  - On inst_req && inst_addr_ok: push fetch_pc into the in-flight FIFO, increment out_cnt, and set fetch_pc ← fetch_pc + 4.
- Response:
  - On inst_data_ok, pop the in-flight FIFO and decrement out_cnt.
  - If disc_cnt > 0: drop the response and decrement disc_cnt.
  - Otherwise: enqueue {pc, inst_rdata, ex}.
- Dequeue: a pop occurs when fs_to_ds_valid && ds_allowin.
- Priority: ws_ex > eret > br_taken.
- ws_ex or eret (full flush):
  - q_cnt ← 0.
  - disc_cnt ← out_cnt minus any response consumed that cycle.
  - hold ← 0; slot state ← SLOT_IDLE.
  - fetch_pc ← EX_ENTRY or cp0_epc.
- br_taken (delay-slot preservation):
  - If q_cnt ≥ 1: keep the head entry only, drop the rest, set disc_cnt ← out_cnt, and set fetch_pc ← br_target.
  - Else if out_cnt ≥ 1: keep the first arriving response, discard the remaining out_cnt − 1, set fetch_pc ← br_target, and enter SLOT_WAIT_RESP until that response arrives.
  - Else: store pend_target and enter SLOT_WAIT_ISSUE. The next accepted request (the delay slot, at fetch_pc) loads fetch_pc ← pend_target instead of +4, then returns to SLOT_IDLE.
- br_stall only suppresses issue. The queue still drains, and responses are still accepted.
- Counter width: $clog2(FQ_DEPTH+1). The issue rule guarantees no queue or FIFO overflow; any overflow is a design error.

## Timing
- Reset values:
  - fs_to_ds_valid 0, inst_req 0, fs_to_ds_bus 0.
  - All counters 0; fetch_pc RESET_PC; hold 0.
- inst_req and inst_addr are combinational from registered state and the redirect inputs. They are held steady until addr_ok.
- Latency: data_ok in cycle N → fs_to_ds_valid in cycle N+1.
- Best-case throughput is 1 instruction/cycle when addr_ok and data_ok are both continuously asserted.
- A redirect in cycle N lets the first target request assert in cycle N+1.
- Push and pop in the same cycle are allowed, including when the queue is full; q_cnt is unchanged.
- A flush in the same cycle as data_ok discards that response.
- A flush in the same cycle as a pop: the pop is lost, and the flush wins.
- Reset asserted mid-transaction clears all state immediately. The bench must deassert data_ok for stale responses after reset.

## Configuration
- FS_ADEL_CHECK_EN defined:
  - A request issued with fetch_pc[1:0] != 0 tags its entry with pc_error = 1, ex_code = `ADEL, and BadVAddr = pc.
  - hold is then set, and issue stops until ws_ex or eret.
- FS_ADEL_CHECK_EN undefined:
  - pc_error = 0, ex_code = `NO_EX, and BadVAddr = 0 always.
  - hold is never set.

## Test plan
- Reset release, addr_ok/data_ok tied 1, ds_allowin 1 → PCs 0xbfc00000, 0xbfc00004, … at 1 instr/cycle, with first valid 2 cycles after reset release.
- ds_allowin 0 for 10 cycles, FQ_DEPTH = 4 → exactly 4 requests accepted, then inst_req 0; on release, 4 ordered entries drain and fetching resumes.
- 3 requests outstanding, ws_ex pulse → the 3 late responses are dropped; next valid pc is 0xbfc00380.
- br_taken to 0x80001000 with q_cnt = 2 (pc 0x100, 0x104) → 0x100 delivered, 0x104 dropped, next 0x80001000. Repeat with q_cnt = 0, out_cnt = 0 → 0x100 fetched, then 0x80001000.
- eret with cp0_epc = 0x80000002 and FS_ADEL_CHECK_EN defined → one entry with pc_error 1, ex_code ADEL, BadVAddr 0x80000002, then inst_req stays 0 until ws_ex.
- br_stall 1 for 5 cycles with queue non-empty → no new requests; the queue drains and in-flight responses are still enqueued.
